uart_receiver: RTL

//   8N1 UART receiver: deserialises the RXD line into bytes, LSB first, 1 start, 8 data, 1 stop.
//   Bit timing uses the same REF = CLK_FREQ/BAUD cycle count as BaudGenerator.
//   The bit counter is internal and re-phased on every start edge, because an RX line

---
 rtl/uart_defs_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_receiver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encodings, default line settings and
// the cycles-per-bit derivation used by the receiver, transmitter and baud generator.
package uart_defs;

    localparam int unsigned DEF_CLK_FREQ = 100000000;
    localparam int unsigned DEF_BAUD     = 115200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Whole clock cycles per bit period
    function automatic int unsigned calc_ref(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Cycles from start-edge detection to the middle of the start bit
    function automatic int unsigned calc_href(input int unsigned clk_freq,
                                              input int unsigned baud);
        return calc_ref(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen by the instantiator so idle-high and idle-low lines both come up quiet.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next value of each stage is simply the previous stage
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Synchroniser flops, forced to the idle level during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. The bit counter restarts on each detected start edge so
// every sample lands in the middle of its bit; received bytes are offered on a
// valid/ready holding register with frame-error and overrun pulses.
module uart_receiver
    import uart_defs::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam logic [31:0] REF   = 32'(calc_ref(CLK_FREQ, BAUD));
    localparam logic [31:0] H_REF = 32'(calc_href(CLK_FREQ, BAUD));

    logic        rxs;
    uart_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        bit_tick;
    logic        stop_tick;
    logic        busy;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rxd_sync (
        .clk  (CLK),
        .rst_n(RST),
        .d_in (RXD),
        .q_out(rxs)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start-bit qualification, 8 data bits, stop check, break wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rxs) state_d = ST_START;
            ST_START: if (cnt_q == H_REF - 32'd1) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if ((cnt_q == REF - 32'd1) && (bitidx_q == 3'd7)) state_d = ST_STOP;
            ST_STOP:  if (cnt_q == REF - 32'd1) state_d = rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM-decoded strobes: data-bit sample point, stop-bit sample point, busy flag
    always_comb begin
        bit_tick  = (state_q == ST_DATA) && (cnt_q == REF - 32'd1);
        stop_tick = (state_q == ST_STOP) && (cnt_q == REF - 32'd1);
        busy      = (state_q != ST_IDLE);
    end

    // Datapath next values: bit counter, shift register, holding register and pulses
    always_comb begin
        cnt_d    = cnt_q + 32'd1;
        bitidx_d = bitidx_q;
        sr_d     = sr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        // Counter restarts on each state change and each data-bit sample;
        // it is held at zero while waiting for an edge.
        if ((state_d != state_q) || bit_tick ||
            (state_q == ST_IDLE) || (state_q == ST_BREAK)) begin
            cnt_d = '0;
        end

        if ((state_q == ST_START) && (state_d == ST_DATA)) begin
            bitidx_d = '0;
        end

        // LSB arrives first, so shift right and insert at the top
        if (bit_tick) begin
            sr_d     = {rxs, sr_q[7:1]};
            bitidx_d = bitidx_q + 3'd1;
        end

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        // A completed byte loads only if the slot is free or being emptied now
        if (stop_tick) begin
            if (rxs) begin
                if (!valid_q || READY) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            bitidx_q <= '0;
            sr_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            sr_q     <= sr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign FERR    = ferr_q;
    assign OVERRUN = ovr_q;
    assign BUSY    = busy;

endmodule
